// File: rtl/sobel_udiv_29ns_8ns.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Valid/ready on both sides; one operation in flight at a time.
module sobel_udiv_29ns_8ns #(
   parameter int DIVIDEND_WIDTH = 29,
   parameter int DIVISOR_WIDTH  = 8
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] din0,
   input  logic [DIVISOR_WIDTH-1:0]  din1,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIVIDEND_WIDTH-1:0] quot,
   output logic [DIVISOR_WIDTH-1:0]  rem,
   output logic                      div_by_zero
);

   localparam int N  = DIVIDEND_WIDTH;
   localparam int M  = DIVISOR_WIDTH;
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q;
   logic [N-1:0]    shift_q;
   logic [N-1:0]    quot_q;
   logic [M-1:0]    div_q;
   logic [M-1:0]    rem_q;
   logic [M:0]      prem_q;
   logic [CW-1:0]   count_q;
   logic            out_valid_q;
   logic            dbz_q;

   logic [M:0]      t_d;
   logic [M:0]      prem_d;
   logic            bit_d;
   logic [N-1:0]    shift_d;

   // Partial remainder carries one extra bit so the compare cannot wrap.
   always_comb begin
      t_d     = {prem_q[M-1:0], shift_q[N-1]};
      bit_d   = (t_d >= {1'b0, div_q});
      prem_d  = bit_d ? (t_d - {1'b0, div_q}) : t_d;
      shift_d = {shift_q[N-2:0], bit_d};
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         quot_q      <= '0;
         div_q       <= '0;
         rem_q       <= '0;
         prem_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  shift_q <= din0;
                  div_q   <= din1;
                  prem_q  <= '0;
                  count_q <= '0;
                  if (din1 == '0) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     quot_q      <= '1;
                     rem_q       <= '0;
                     dbz_q       <= 1'b1;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               shift_q <= shift_d;
               prem_q  <= prem_d;
               if (count_q == CW'(N - 1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  quot_q      <= shift_d;
                  rem_q       <= prem_d[M-1:0];
                  dbz_q       <= 1'b0;
               end else begin
                  count_q <= count_q + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = !ap_rst && (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quot        = quot_q;
   assign rem         = rem_q;
   assign div_by_zero = dbz_q;

   a_rem_lt_div: assert property (
      @(posedge ap_clk) disable iff (ap_rst)
      (state_q != IDLE && div_q != '0) |-> (prem_q < {1'b0, div_q})
   );

endmodule
